net_to_tran: RTL and testbench
==============================

Name: net_to_tran

Overview:
Receive-side counterpart of the transport-to-network packetiser. It accepts fixed-length packets byte-serially from the network layer and strips the leading byte, which is the source phone number. It then buffers the payload and hands it to the transport layer through a read-strobe interface. Only complete packets become visible to the transport side: partial packets are rolled back and unroomable packets are dropped.

Parameters:
PACKET_SIZE, 16, bytes per packet including the phone byte (payload = PACKET_SIZE-1).
DEPTH_LOG2, 9, log2 of payload buffer depth (512 bytes).
TIMEOUT, 64, maximum idle cycles between bytes inside a packet before the packet is aborted.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  asynchronous, active-low reset (asserted when 0).
packetIn  input  8  byte from the network layer.
packetValid  input  1  packetIn is valid this cycle.
tranRd  input  1  transport-layer read strobe.
recvReady  output  1  high in S_IDLE when at least PACKET_SIZE-1 bytes are free.
dataOut  output  8  payload byte, valid when dataValid=1.
dataValid  output  1  high one cycle after an accepted tranRd.
bufEmpty  output  1  no committed payload bytes available.
bufCount  output  DEPTH_LOG2+1  committed, unread payload bytes.
phoneNum  output  8  source phone of the most recently committed packet.
packetReady  output  1  one-cycle pulse per committed packet.
dropCount  output  8  packets dropped or aborted; saturates at 255.
debug  output  3  current state encoding.

Behaviour:
- Reset (reset=0, async) clears:
  - outputs: dataOut, dataValid, packetReady, phoneNum, dropCount = 0; bufCount = 0; bufEmpty = 1.
  - internal: state = S_IDLE; both write pointers and the read pointer = 0.
  - Reset mid-packet discards all buffered and partial data.
- Buffer: two write pointers, wrPtr (speculative) and wrCommit, plus rdPtr.
  - bufCount = wrCommit - rdPtr, width DEPTH_LOG2+1, modulo wrap.
  - free = 2^DEPTH_LOG2 - (wrPtr - rdPtr).
- Read side:
  - tranRd with bufEmpty=0 → rdPtr+1; dataOut is registered with a latency of 1 cycle, and dataValid=1 on that cycle.
  - tranRd with bufEmpty=1 is ignored (dataValid=0, no pointer change).
  - Reads never see uncommitted bytes.
- States (debug encoding): S_IDLE=0, S_PAYLOAD=1, S_DROP=2.
- S_IDLE:
  - packetValid with free ≥ PACKET_SIZE-1: latch packetIn into phonePend, cnt=0, go to S_PAYLOAD.
  - packetValid with insufficient free: cnt=0, go to S_DROP.
- S_PAYLOAD:
  - Each packetValid writes packetIn at wrPtr; wrPtr+1, cnt+1, gap timer cleared.
  - When the written byte makes cnt reach PACKET_SIZE-1:
    - wrCommit takes the new wrPtr on the same edge; phoneNum = phonePend.
    - packetReady pulses on the following cycle; return to S_IDLE.
  - Back-to-back packets are allowed: the next phone byte may arrive on the cycle after the last payload byte.
- S_DROP: consume and discard bytes until PACKET_SIZE-1 have arrived, then dropCount+1 (saturating) and go to S_IDLE.
- Gap timeout: in S_PAYLOAD or S_DROP, TIMEOUT consecutive cycles with packetValid=0 triggers an abort:
  - wrPtr = wrCommit (rollback), dropCount+1, go to S_IDLE.
  - phoneNum is unchanged.
- Simultaneous tranRd and a payload write in the same cycle are both honoured.
- Free-space check happens only at the phone byte. An overflow mid-packet is impossible by construction.
- packetValid while recvReady=0 (e.g. in S_IDLE with no room) is handled as a drop, not an error.

Decomposition:
- Shared package (net_pkg):
  - state encodings S_IDLE/S_PAYLOAD/S_DROP;
  - default PACKET_SIZE;
  - phone-byte position constant (0).
- One sub-module, rx_commit_fifo:
  - dual-pointer synchronous RAM FIFO with wr_en, commit and rollback inputs;
  - outputs committed count, empty and free.
- The FSM, timer and counters remain in net_to_tran.

Test Plan:
1. Send phone 0x2A then payload 0x01..0x0F contiguously → packetReady pulses once on the cycle after byte 16; phoneNum=0x2A; bufCount=15. Then 15 tranRd reads → dataOut 0x01..0x0F each with dataValid one cycle after its read; bufEmpty=1 at end.
2. Send phone 0x05 plus 7 payload bytes, then hold packetValid low for 64 cycles → dropCount=1, bufCount=0, phoneNum unchanged. A following full packet commits correctly.
3. Fill the buffer to 500 committed bytes with no reads (recvReady=0), then send a 16-byte packet → S_DROP, dropCount+1, bufCount stays 500, packetReady is never asserted.
4. Two packets back-to-back (32 consecutive valid bytes) while tranRd is asserted continuously → two packetReady pulses, 30 bytes are delivered in order, and no byte is lost or duplicated.
5. Assert reset=0 asynchronously mid-payload, then release → all outputs return to reset values, bufEmpty=1, and the next packet is received normally.
6. Issue tranRd while bufEmpty=1 → dataValid stays 0 and the pointers are unchanged. Also check pointer wrap after 40 packets (600 bytes) at depth 512: data integrity holds.

Source files
------------

// File: rtl/net_pkg.sv
// Shared constants for the network-to-transport receive path.
package net_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PAYLOAD = 3'd1;
  localparam logic [2:0] S_DROP    = 3'd2;

  localparam int PACKET_SIZE_DEF = 16;
  localparam int PHONE_POS       = 0;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rx_commit_fifo.sv
// Byte FIFO with a speculative write pointer that is either committed or rolled back.
module rx_commit_fifo #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  input  logic                commit,
  input  logic                rollback,
  input  logic                rd_en,
  output logic [7:0]          rd_data,
  output logic                rd_valid,
  output logic [DEPTH_LOG2:0] count,
  output logic [DEPTH_LOG2:0] free,
  output logic                empty
);

  localparam int PTR_W = DEPTH_LOG2 + 1;

  logic [7:0]       mem_q [2**DEPTH_LOG2];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] wr_commit_q, wr_commit_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_fire_s;

  assign empty    = (wr_commit_q == rd_ptr_q);
  assign count    = wr_commit_q - rd_ptr_q;
  assign free     = PTR_W'(2**DEPTH_LOG2) - (wr_ptr_q - rd_ptr_q);
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  // Pointer and read-register next-state; commit captures the post-write pointer
  always_comb begin
    rd_fire_s = rd_en && !empty;
    if (rollback) begin
      wr_ptr_d = wr_commit_q;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (commit) begin
      wr_commit_d = wr_ptr_d;
    end else begin
      wr_commit_d = wr_commit_q;
    end
    if (rd_fire_s) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      rd_data_d = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    end else begin
      rd_ptr_d  = rd_ptr_q;
      rd_data_d = rd_data_q;
    end
    rd_valid_d = rd_fire_s;
  end

  // Payload storage
  always_ff @(posedge clk) begin
    if (wr_en && !rollback) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  // Pointer and read-data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= PTR_W'(0);
      wr_commit_q <= PTR_W'(0);
      rd_ptr_q    <= PTR_W'(0);
      rd_data_q   <= 8'd0;
      rd_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

endmodule

// File: rtl/net_to_tran.sv
// Strips the phone byte from fixed-length network packets and exposes only
// fully received payloads to the transport layer.
module net_to_tran
  import net_pkg::*;
#(
  parameter int PACKET_SIZE = PACKET_SIZE_DEF,
  parameter int DEPTH_LOG2  = 9,
  parameter int TIMEOUT     = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          packetIn,
  input  logic                packetValid,
  input  logic                tranRd,
  output logic                recvReady,
  output logic [7:0]          dataOut,
  output logic                dataValid,
  output logic                bufEmpty,
  output logic [DEPTH_LOG2:0] bufCount,
  output logic [7:0]          phoneNum,
  output logic                packetReady,
  output logic [7:0]          dropCount,
  output logic [2:0]          debug
);

  localparam int CNT_W  = $clog2(PACKET_SIZE);
  localparam int GAP_W  = $clog2(TIMEOUT + 1);
  localparam int FREE_W = DEPTH_LOG2 + 1;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [7:0]        phone_pend_q, phone_pend_d;
  logic [7:0]        phone_num_q, phone_num_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic              pkt_ready_q, pkt_ready_d;
  logic              wr_en_s, commit_s, rollback_s, room_s, last_s;
  logic [FREE_W-1:0] free_s;

  rx_commit_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .wr_en    (wr_en_s),
    .wr_data  (packetIn),
    .commit   (commit_s),
    .rollback (rollback_s),
    .rd_en    (tranRd),
    .rd_data  (dataOut),
    .rd_valid (dataValid),
    .count    (bufCount),
    .free     (free_s),
    .empty    (bufEmpty)
  );

  assign room_s      = (free_s >= FREE_W'(PACKET_SIZE - 1));
  assign last_s      = (cnt_q == CNT_W'(PACKET_SIZE - 2));
  assign recvReady   = (state_q == S_IDLE) && room_s;
  assign phoneNum    = phone_num_q;
  assign packetReady = pkt_ready_q;
  assign dropCount   = drop_cnt_q;
  assign debug       = state_q;

  // Packet FSM: room is judged once at the phone byte, so payload writes never overflow
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    phone_pend_d = phone_pend_q;
    phone_num_d  = phone_num_q;
    drop_cnt_d   = drop_cnt_q;
    pkt_ready_d  = 1'b0;
    wr_en_s      = 1'b0;
    commit_s     = 1'b0;
    rollback_s   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = CNT_W'(PHONE_POS);
        gap_d = GAP_W'(0);
        if (packetValid && room_s) begin
          phone_pend_d = packetIn;
          state_d      = S_PAYLOAD;
        end else if (packetValid) begin
          state_d = S_DROP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PAYLOAD, S_DROP: begin
        if (packetValid) begin
          gap_d   = GAP_W'(0);
          cnt_d   = cnt_q + CNT_W'(1);
          wr_en_s = (state_q == S_PAYLOAD);
          if (last_s && (state_q == S_PAYLOAD)) begin
            commit_s    = 1'b1;
            phone_num_d = phone_pend_q;
            pkt_ready_d = 1'b1;
            state_d     = S_IDLE;
          end else if (last_s) begin
            drop_cnt_d = sat_inc8(drop_cnt_q);
            state_d    = S_IDLE;
          end else begin
            state_d = state_q;
          end
        end else if (gap_q == GAP_W'(TIMEOUT - 1)) begin
          rollback_s = 1'b1;
          drop_cnt_d = sat_inc8(drop_cnt_q);
          state_d    = S_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM and status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= CNT_W'(0);
      gap_q        <= GAP_W'(0);
      phone_pend_q <= 8'd0;
      phone_num_q  <= 8'd0;
      drop_cnt_q   <= 8'd0;
      pkt_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      phone_pend_q <= phone_pend_d;
      phone_num_q  <= phone_num_d;
      drop_cnt_q   <= drop_cnt_d;
      pkt_ready_q  <= pkt_ready_d;
    end
  end

endmodule

// File: tb/tb_net_to_tran.sv
// Directed bench for net_to_tran with a queue-based reference model checked every cycle.
module tb_net_to_tran;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] packetIn = 8'd0;
  logic       packetValid = 1'b0;
  logic       tranRd = 1'b0;
  logic       recvReady;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       bufEmpty;
  logic [9:0] bufCount;
  logic [7:0] phoneNum;
  logic       packetReady;
  logic [7:0] dropCount;
  logic [2:0] debug;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  net_to_tran dut (
    .clk         (clk),
    .reset       (reset),
    .packetIn    (packetIn),
    .packetValid (packetValid),
    .tranRd      (tranRd),
    .recvReady   (recvReady),
    .dataOut     (dataOut),
    .dataValid   (dataValid),
    .bufEmpty    (bufEmpty),
    .bufCount    (bufCount),
    .phoneNum    (phoneNum),
    .packetReady (packetReady),
    .dropCount   (dropCount),
    .debug       (debug)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: committed bytes, pending payload, mode 0 idle / 1 receiving / 2 discarding
  logic [7:0] mq[$];
  logic [7:0] pend[$];
  int         m_mode = 0, m_idle = 0, m_n = 0, m_drops = 0, m_free = 0;
  logic [7:0] m_phone_p = 8'd0, m_phone = 8'd0, m_data = 8'd0;
  bit         m_valid = 1'b0, m_pr = 1'b0;

  task automatic m_abort();
    pend.delete();
    if (m_drops < 255) m_drops++;
    m_mode = 0;
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      mq.delete(); pend.delete();
      m_mode = 0; m_idle = 0; m_n = 0; m_drops = 0;
      m_phone = 8'd0; m_data = 8'd0; m_valid = 1'b0; m_pr = 1'b0;
    end else begin
      m_valid = 1'b0;
      m_pr = 1'b0;
      m_free = 512 - mq.size() - pend.size();
      if (tranRd && mq.size() > 0) begin
        m_data = mq.pop_front();
        m_valid = 1'b1;
      end
      if (m_mode == 0) begin
        if (packetValid) begin
          m_idle = 0;
          if (m_free >= 15) begin
            m_phone_p = packetIn; pend.delete(); m_mode = 1;
          end else begin
            m_n = 0; m_mode = 2;
          end
        end
      end else if (packetValid) begin
        m_idle = 0;
        if (m_mode == 1) begin
          pend.push_back(packetIn);
          if (pend.size() == 15) begin
            foreach (pend[i]) mq.push_back(pend[i]);
            pend.delete();
            m_phone = m_phone_p; m_pr = 1'b1; m_mode = 0;
          end
        end else begin
          m_n++;
          if (m_n == 15) begin
            if (m_drops < 255) m_drops++;
            m_mode = 0;
          end
        end
      end else begin
        m_idle++;
        if (m_idle == 64) m_abort();
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("bufCount", 32'(bufCount), 32'(mq.size()));
      check("bufEmpty", 32'(bufEmpty), 32'(mq.size() == 0));
      check("phoneNum", 32'(phoneNum), 32'(m_phone));
      check("dropCount", 32'(dropCount), 32'(m_drops));
      check("packetReady", 32'(packetReady), 32'(m_pr));
      check("dataValid", 32'(dataValid), 32'(m_valid));
      check("dataOut", 32'(dataOut), 32'(m_data));
      check("debug", 32'(debug), 32'(m_mode));
      check("recvReady", 32'(recvReady), 32'((m_mode == 0) && (512 - mq.size() >= 15)));
    end
  end

  logic [7:0] got[$];
  int npr = 0;
  always @(negedge clk) begin
    if (dataValid === 1'b1) got.push_back(dataOut);
    if (packetReady === 1'b1) npr++;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    packetValid = 1'b1;
    packetIn = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      packetValid = 1'b0;
    end
  endtask

  task automatic send_pkt(input logic [7:0] ph, input logic [7:0] base);
    send_byte(ph);
    for (int i = 1; i < 16; i++) send_byte(8'(base + 8'(i)));
  endtask

  task automatic read_n(input int n);
    repeat (n) begin
      @(negedge clk);
      packetValid = 1'b0;
      tranRd = 1'b1;
    end
    @(negedge clk);
    tranRd = 1'b0;
  endtask

  int snap;
  int bad;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_dataValid", 32'(dataValid), 32'd0);
    check("rst_bufEmpty", 32'(bufEmpty), 32'd1);
    check("rst_bufCount", 32'(bufCount), 32'd0);
    check("rst_dropCount", 32'(dropCount), 32'd0);
    check("rst_phoneNum", 32'(phoneNum), 32'd0);
    check("rst_packetReady", 32'(packetReady), 32'd0);
    cmp_en = 1'b1;
    reset = 1'b1;
    idle(2);

    // 1: single packet then read it out
    send_pkt(8'h2A, 8'h00);
    idle(2);
    check("t1_phone", 32'(phoneNum), 32'h2A);
    check("t1_count", 32'(bufCount), 32'd15);
    check("t1_npr", 32'(npr), 32'd1);
    got.delete();
    read_n(15);
    idle(2);
    check("t1_nread", 32'(got.size()), 32'd15);
    bad = 0;
    foreach (got[i]) if (got[i] !== 8'(i + 1)) bad++;
    check("t1_data", 32'(bad), 32'd0);
    check("t1_empty", 32'(bufEmpty), 32'd1);

    // 2: gap timeout boundary, then a good packet
    send_byte(8'h05);
    for (int i = 1; i <= 7; i++) send_byte(8'(i));
    idle(64);
    check("t2_still_rx", 32'(debug), 32'd1);
    idle(1);
    check("t2_abort_state", 32'(debug), 32'd0);
    check("t2_drop", 32'(dropCount), 32'd1);
    check("t2_count", 32'(bufCount), 32'd0);
    check("t2_phone", 32'(phoneNum), 32'h2A);
    send_pkt(8'h33, 8'h40);
    idle(2);
    check("t2_phone2", 32'(phoneNum), 32'h33);
    check("t2_count2", 32'(bufCount), 32'd15);
    read_n(15);
    idle(2);

    // 3: fill to 500 committed bytes, then a packet with no room is dropped
    for (int k = 0; k < 34; k++) send_pkt(8'(8'hA0 + 8'(k)), 8'(k));
    idle(2);
    check("t3_full", 32'(bufCount), 32'd510);
    read_n(10);
    idle(2);
    check("t3_500", 32'(bufCount), 32'd500);
    check("t3_notready", 32'(recvReady), 32'd0);
    snap = npr;
    send_pkt(8'h77, 8'h80);
    idle(2);
    check("t3_drop", 32'(dropCount), 32'd2);
    check("t3_count", 32'(bufCount), 32'd500);
    check("t3_npr", 32'(npr - snap), 32'd0);
    check("t3_phone", 32'(phoneNum), 32'hC1);
    read_n(500);
    idle(2);
    check("t3_empty", 32'(bufEmpty), 32'd1);

    // 4: back-to-back packets with continuous reads
    got.delete();
    snap = npr;
    tranRd = 1'b1;
    send_pkt(8'h11, 8'h20);
    send_pkt(8'h12, 8'h50);
    idle(20);
    tranRd = 1'b0;
    idle(2);
    check("t4_npr", 32'(npr - snap), 32'd2);
    check("t4_nread", 32'(got.size()), 32'd30);
    bad = 0;
    foreach (got[i]) if (got[i] !== ((i < 15) ? 8'(8'h21 + 8'(i)) : 8'(8'h51 + 8'(i - 15)))) bad++;
    check("t4_data", 32'(bad), 32'd0);

    // 5: async reset in the middle of a packet, with committed data pending
    send_pkt(8'h61, 8'h70);
    send_byte(8'h62);
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    @(negedge clk);
    packetValid = 1'b0;
    #2 reset = 1'b0;
    #10 reset = 1'b1;
    idle(2);
    check("t5_empty", 32'(bufEmpty), 32'd1);
    check("t5_count", 32'(bufCount), 32'd0);
    check("t5_drop", 32'(dropCount), 32'd0);
    check("t5_phone", 32'(phoneNum), 32'd0);
    check("t5_state", 32'(debug), 32'd0);
    send_pkt(8'h63, 8'h90);
    idle(2);
    check("t5_phone2", 32'(phoneNum), 32'h63);
    check("t5_count2", 32'(bufCount), 32'd15);
    got.delete();
    read_n(15);
    idle(2);
    check("t5_last", 32'(got.size() == 15 ? got[14] : 8'h00), 32'h9F);

    // 6: reads on empty are ignored; 40 packets wrap the 512-byte buffer
    got.delete();
    read_n(3);
    idle(2);
    check("t6_noread", 32'(got.size()), 32'd0);
    check("t6_count", 32'(bufCount), 32'd0);
    tranRd = 1'b1;
    for (int k = 0; k < 40; k++) send_pkt(8'(k), 8'(k * 16));
    idle(20);
    tranRd = 1'b0;
    idle(2);
    check("t6_nread", 32'(got.size()), 32'd600);
    bad = 0;
    foreach (got[j]) if (got[j] !== 8'((j / 15) * 16 + (j % 15) + 1)) bad++;
    check("t6_data", 32'(bad), 32'd0);
    check("t6_last", 32'(got.size() == 600 ? got[599] : 8'h00), 32'h7F);
    check("t6_phone", 32'(phoneNum), 32'd39);
    check("t6_drop", 32'(dropCount), 32'd0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
